// File: rtl/aes_pkg.sv
// Shared AES byte-substitution constants: forward/inverse S-box tables and mode encodings.
// The tables are built at elaboration from the GF(2^8) inverse and the AES affine map.
package aes_pkg;

    localparam int   AES_BYTE_W = 8;
    localparam logic MODE_FWD   = 1'b0;
    localparam logic MODE_INV   = 1'b1;
    localparam int   SBOX_TBL_W = 256 * AES_BYTE_W;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Multiplicative inverse via exp/log tables over generator 3, then the affine map.
    function automatic logic [SBOX_TBL_W-1:0] gen_fwd_tbl();
        logic [7:0]            exp_t [256];
        logic [7:0]            log_t [256];
        logic [7:0]            p;
        logic [7:0]            inv;
        logic [SBOX_TBL_W-1:0] tbl;
        int                    e;
        p   = 8'h01;
        tbl = '0;
        for (int i = 0; i < 256; i++) begin
            exp_t[i] = 8'h00;
            log_t[i] = 8'h00;
        end
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = p;
            log_t[p] = 8'(i);
            p        = p ^ gf_xtime(p);
        end
        for (int x = 0; x < 256; x++) begin
            if (x == 0) begin
                inv = 8'h00;
            end else begin
                e   = (255 - int'(log_t[x])) % 255;
                inv = exp_t[e];
            end
            tbl[x*8 +: 8] = sbox_affine(inv);
        end
        return tbl;
    endfunction

    function automatic logic [SBOX_TBL_W-1:0] gen_inv_tbl(input logic [SBOX_TBL_W-1:0] fwd);
        logic [SBOX_TBL_W-1:0] tbl;
        tbl = '0;
        for (int x = 0; x < 256; x++) begin
            tbl[int'(fwd[x*8 +: 8])*8 +: 8] = 8'(x);
        end
        return tbl;
    endfunction

    localparam logic [SBOX_TBL_W-1:0] SBOX_FWD_TBL = gen_fwd_tbl();
    localparam logic [SBOX_TBL_W-1:0] SBOX_INV_TBL = gen_inv_tbl(SBOX_FWD_TBL);

endpackage

// File: rtl/sbox_lane.sv
// One byte lane of the substitution engine: forward or inverse S-box lookup selected by mode.
module sbox_lane
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] byte_i,
    input  logic                  mode_i,
    output logic [AES_BYTE_W-1:0] byte_o
);

    logic [AES_BYTE_W-1:0] fwd_s;
    logic [AES_BYTE_W-1:0] inv_s;

    assign fwd_s = SBOX_FWD_TBL[{byte_i, 3'b000} +: AES_BYTE_W];
    assign inv_s = SBOX_INV_TBL[{byte_i, 3'b000} +: AES_BYTE_W];

    // Direction mux
    always_comb begin
        byte_o = fwd_s;
        if (mode_i == MODE_INV) begin
            byte_o = inv_s;
        end else begin
            byte_o = fwd_s;
        end
    end

endmodule

// File: rtl/sub_bytes_pipe.sv
// Pipelined multi-lane AES SubBytes/InvSubBytes engine with valid/ready on both sides.
// Lookup sits between stage 0 and stage 1 (before the only register when PIPE_STAGES=1).
module sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int LANES       = 16,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic [AES_BYTE_W*LANES-1:0] in_data,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AES_BYTE_W*LANES-1:0] out_data,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      busy
);

    localparam int DATA_W = AES_BYTE_W * LANES;
    localparam int LAST   = PIPE_STAGES - 1;

    logic [PIPE_STAGES-1:0] stg_valid_s;
    logic [PIPE_STAGES-1:0] stg_ready_s;
    logic [DATA_W-1:0]      stg_data_s [PIPE_STAGES];
    logic [TAG_W-1:0]       stg_tag_s  [PIPE_STAGES];

    logic [DATA_W-1:0]      sub_in_s;
    logic [DATA_W-1:0]      sub_out_s;
    logic                   sub_mode_s;

    // Ready chain: a stage can load when empty or when its downstream can take its beat
    always_comb begin
        stg_ready_s       = '0;
        stg_ready_s[LAST] = !stg_valid_s[LAST] || out_ready;
        for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
            stg_ready_s[k] = !stg_valid_s[k] || stg_ready_s[k+1];
        end
    end

    assign in_ready = rst_n && !flush && stg_ready_s[0];

    // Mode is consumed by the lookup, so only the pre-lookup stage needs to keep it.
    if (PIPE_STAGES == 1) begin : g_sub_direct
        assign sub_in_s   = in_data;
        assign sub_mode_s = in_mode;
    end else begin : g_sub_staged
        logic mode_q;
        logic mode_d;

        // Stage 0 mode next-state
        always_comb begin
            mode_d = mode_q;
            if (!flush && stg_ready_s[0] && in_valid) begin
                mode_d = in_mode;
            end else begin
                mode_d = mode_q;
            end
        end

        // Stage 0 mode register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_q <= MODE_FWD;
            end else begin
                mode_q <= mode_d;
            end
        end

        assign sub_in_s   = stg_data_s[0];
        assign sub_mode_s = mode_q;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sbox_lane u_lane (
            .byte_i (sub_in_s[i*AES_BYTE_W +: AES_BYTE_W]),
            .mode_i (sub_mode_s),
            .byte_o (sub_out_s[i*AES_BYTE_W +: AES_BYTE_W])
        );
    end

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        logic              up_valid_s;
        logic [DATA_W-1:0] up_data_s;
        logic [TAG_W-1:0]  up_tag_s;
        logic              valid_q;
        logic              valid_d;
        logic [DATA_W-1:0] data_q;
        logic [DATA_W-1:0] data_d;
        logic [TAG_W-1:0]  tag_q;
        logic [TAG_W-1:0]  tag_d;

        if (k == 0) begin : g_src_in
            assign up_valid_s = in_valid;
            assign up_tag_s   = in_tag;
            assign up_data_s  = (PIPE_STAGES == 1) ? sub_out_s : in_data;
        end else begin : g_src_stage
            assign up_valid_s = stg_valid_s[k-1];
            assign up_tag_s   = stg_tag_s[k-1];
            assign up_data_s  = (k == 1) ? sub_out_s : stg_data_s[k-1];
        end

        // Stage next-state: flush wins, otherwise load from upstream when ready
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            tag_d   = tag_q;
            if (flush) begin
                valid_d = 1'b0;
            end else if (stg_ready_s[k]) begin
                valid_d = up_valid_s;
                if (up_valid_s) begin
                    data_d = up_data_s;
                    tag_d  = up_tag_s;
                end else begin
                    data_d = data_q;
                    tag_d  = tag_q;
                end
            end else begin
                valid_d = valid_q;
            end
        end

        // Stage registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                tag_q   <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                tag_q   <= tag_d;
            end
        end

        assign stg_valid_s[k] = valid_q;
        assign stg_data_s[k]  = data_q;
        assign stg_tag_s[k]   = tag_q;
    end

    assign out_valid = stg_valid_s[LAST];
    assign out_data  = stg_data_s[LAST];
    assign out_tag   = stg_tag_s[LAST];
    assign busy      = |stg_valid_s;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Scoreboard bench for sub_bytes_pipe: S-box reference derived from GF(2^8) arithmetic.
module tb_sub_bytes_pipe;

    localparam int LANES       = 16;
    localparam int PIPE_STAGES = 2;
    localparam int TAG_W       = 4;
    localparam int DW          = 8 * LANES;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [DW-1:0] in_data;
    logic [TAG_W-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic          busy;

    sub_bytes_pipe #(.LANES(LANES), .PIPE_STAGES(PIPE_STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0]    data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t          sb_q [$];
    logic [DW-1:0] cap_q [$];
    bit            cap_en  = 1'b0;
    bit            bp_rand = 1'b0;

    logic [7:0] m_fwd [256];
    logic [7:0] m_inv [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x, y;
        r = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return r;
    endfunction

    task automatic init_model();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            m_fwd[x] = s;
        end
        for (int x = 0; x < 256; x++) m_inv[m_fwd[x]] = 8'(x);
    endtask

    function automatic logic [DW-1:0] model_sub(input logic [DW-1:0] d, input logic m);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[8*i +: 8] = m ? m_inv[d[8*i +: 8]] : m_fwd[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [DW-1:0] sweep(input int j);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[8*i +: 8] = 8'(16*j + i);
        return r;
    endfunction

    task automatic check_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every output transfer, check hold under stall
    initial begin : monitor
        logic pv, pr, pf;
        logic [DW-1:0] pd;
        logic [TAG_W-1:0] pt;
        exp_t e;
        pv = 1'b0; pr = 1'b0; pf = 1'b0; pd = '0; pt = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                pv = 1'b0;
            end else begin
                if (pv && !pr && !pf) begin
                    check_i("hold_valid", int'(out_valid), 1);
                    check_d("hold_data", out_data, pd);
                    check_i("hold_tag", int'(out_tag), int'(pt));
                end
                if (flush) begin
                    sb_q.delete();
                end else if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: got tag %0d data %h expected no beat", out_tag, out_data);
                    end else begin
                        e = sb_q.pop_front();
                        check_d("out_data", out_data, e.data);
                        check_i("out_tag", int'(out_tag), int'(e.tag));
                        if (cap_en) cap_q.push_back(out_data);
                    end
                end
                pv = out_valid; pr = out_ready; pf = flush; pd = out_data; pt = out_tag;
            end
        end
    end

    // Random back-pressure when enabled
    initial begin : bp_gen
        forever begin
            @(posedge clk);
            #1;
            if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [DW-1:0] d, input logic m, input logic [TAG_W-1:0] t,
                        input logic [DW-1:0] exp);
        bit   done;
        exp_t e;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_tag   = t;
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            if (in_ready) begin
                e.data = exp;
                e.tag  = t;
                sb_q.push_back(e);
                done = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no accept expected accept of tag %0d", t);
        end
    endtask

    task automatic drain();
        for (int w = 0; w < 300 && (sb_q.size() != 0 || busy); w++) step();
        check_i("drain_empty", sb_q.size(), 0);
    endtask

    initial begin : main
        int accepts;
        int c0;
        exp_t e;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
        in_data = '0; in_tag = '0; out_ready = 1'b1;
        init_model();

        // Reset state
        #12;
        check_i("rst_out_valid", int'(out_valid), 0);
        check_d("rst_out_data", out_data, '0);
        check_i("rst_out_tag", int'(out_tag), 0);
        check_i("rst_busy", int'(busy), 0);
        check_i("rst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_i("in_ready_after_rst", int'(in_ready), 1);
        step();

        // Forward known values and 2-cycle latency
        send({16{8'h00}}, 1'b0, 4'd1, {16{8'h63}});
        @(negedge clk); check_i("lat1_valid_c1", int'(out_valid), 0);
        step();
        @(negedge clk); check_i("lat1_valid_c2", int'(out_valid), 1);
        step();
        send({16{8'h53}}, 1'b0, 4'd2, {16{8'hED}});
        @(negedge clk); check_i("lat2_valid_c1", int'(out_valid), 0);
        step();
        @(negedge clk);
        check_i("lat2_valid_c2", int'(out_valid), 1);
        check_d("lat2_data", out_data, {16{8'hED}});
        step();

        // Inverse known values
        send({16{8'h63}}, 1'b1, 4'd3, {16{8'h00}});
        send({16{8'hED}}, 1'b1, 4'd4, {16{8'h53}});
        send({16{8'h00}}, 1'b1, 4'd5, {16{8'h52}});
        drain();

        // Full byte sweep in each mode, then chain results back through the opposite mode
        for (int pass = 0; pass < 2; pass++) begin
            cap_q.delete();
            cap_en = 1'b1;
            for (int j = 0; j < 16; j++)
                send(sweep(j), pass[0], 4'(j), model_sub(sweep(j), pass[0]));
            drain();
            cap_en = 1'b0;
            check_i("capture_count", cap_q.size(), 16);
            for (int j = 0; j < 16 && j < cap_q.size(); j++)
                send(cap_q[j], !pass[0], 4'(j), sweep(j));
            drain();
        end

        // Back-pressure: stall output for 5 cycles under continuous input
        out_ready = 1'b0;
        accepts   = 0;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_data = {16{8'(accepts * 17 + 1)}};
            in_tag  = 4'(accepts);
            @(negedge clk);
            if (in_ready) begin
                e.data = model_sub(in_data, 1'b0);
                e.tag  = in_tag;
                sb_q.push_back(e);
                accepts++;
            end
            step();
        end
        check_i("accepts_before_stall", accepts, 2);
        @(negedge clk);
        check_i("in_ready_stalled", int'(in_ready), 0);
        check_i("out_valid_stalled", int'(out_valid), 1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = accepts; t < 10; t++)
            send({16{8'(t * 17 + 1)}}, 1'b0, 4'(t), model_sub({16{8'(t * 17 + 1)}}, 1'b0));
        drain();

        // Alternating modes at full rate
        c0 = cyc;
        for (int k = 0; k < 8; k++)
            send({16{8'h01}}, k[0], 4'(k), k[0] ? {16{8'h09}} : {16{8'h7C}});
        check_i("alt_full_rate_cycles", cyc - c0, 8);
        drain();

        // Flush with two beats in flight and a coincident input beat
        out_ready = 1'b0;
        send({16{8'hA5}}, 1'b0, 4'd11, model_sub({16{8'hA5}}, 1'b0));
        send({16{8'h5A}}, 1'b1, 4'd12, model_sub({16{8'h5A}}, 1'b1));
        in_valid = 1'b1; in_data = {16{8'h3C}}; in_tag = 4'd13; flush = 1'b1;
        @(negedge clk);
        check_i("flush_in_ready", int'(in_ready), 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_i("flush_busy", int'(busy), 0);
        check_i("flush_out_valid", int'(out_valid), 0);
        step();
        out_ready = 1'b1;
        for (int w = 0; w < 5; w++) step();

        // Reset mid-flight
        send({16{8'h11}}, 1'b0, 4'd14, model_sub({16{8'h11}}, 1'b0));
        send({16{8'h22}}, 1'b1, 4'd15, model_sub({16{8'h22}}, 1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check_i("midrst_out_valid", int'(out_valid), 0);
        check_d("midrst_out_data", out_data, '0);
        check_i("midrst_out_tag", int'(out_tag), 0);
        check_i("midrst_busy", int'(busy), 0);
        check_i("midrst_in_ready", int'(in_ready), 0);
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        check_i("midrst_in_ready_after", int'(in_ready), 1);
        step();
        for (int w = 0; w < 4; w++) step();

        // Randomized traffic with random back-pressure
        bp_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [DW-1:0] d;
            logic m;
            d = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) step();
            send(d, m, 4'(n), model_sub(d, m));
        end
        bp_rand = 1'b0;
        step();
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
